// File: rtl/leb128_encoder.sv
// -----------------------------------------------------------------------------
// leb128_encoder
// Serialises one stack value (value + result type) into WebAssembly immediate
// byte format: LEB128 (unsigned or signed) for i32/i64, raw little-endian bytes
// for f32/f64. One value is accepted via valid/ready; its bytes then leave one
// per cycle via valid/ready, with out_last marking the final byte.
//
// Ports
//   clk        in   1   clock, all logic on posedge
//   reset      in   1   synchronous active-low reset
//   in_value   in   64  value; i32/f32 use bits [31:0]
//   in_type    in   2   0=i32, 1=i64, 2=f32, 3=f64 (cpu type codes)
//   in_signed  in   1   1 = SLEB128, 0 = ULEB128 (ignored for f32/f64)
//   in_valid   in   1   value offered
//   in_ready   out  1   encoder idle, value accepted on in_valid && in_ready
//   out_byte   out  8   encoded byte
//   out_valid  out  1   out_byte valid
//   out_ready  in   1   sink takes byte on out_valid && out_ready
//   out_last   out  1   out_byte is the final byte of the value
// -----------------------------------------------------------------------------
module leb128_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] in_value,
   input  logic [1:0]  in_type,
   input  logic        in_signed,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last
);

   localparam logic [1:0] TYPE_I32 = 2'd0;
   localparam logic [1:0] TYPE_I64 = 2'd1;
   localparam logic [1:0] TYPE_F32 = 2'd2;
   localparam logic [1:0] TYPE_F64 = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]  r_state;
   logic [63:0] r_work;
   logic [1:0]  r_type;
   logic        r_signed;
   logic [3:0]  r_cnt;
   logic [7:0]  r_out_byte;
   logic        r_out_valid;
   logic        r_out_last;

   logic [63:0] w_ext;
   logic [63:0] w_src_work;
   logic [1:0]  w_src_type;
   logic        w_src_signed;
   logic [3:0]  w_src_cnt;
   logic [72:0] w_step;
   logic [63:0] w_rest;
   logic        w_done;
   logic [7:0]  w_byte;
   logic        w_byte_taken;

   // One encoding step: returns {remaining work, last flag, byte to emit}.
   // cnt is the index of the byte being produced.
   function automatic logic [72:0] enc_step(
      input logic [63:0] work,
      input logic [1:0]  typ,
      input logic        sgn,
      input logic [3:0]  cnt
   );
      logic [63:0] rest;
      logic [6:0]  low7;
      logic        done;
      logic [7:0]  b;
      rest = 64'd0;
      low7 = 7'd0;
      done = 1'b0;
      b    = 8'h00;
      case (typ)
         TYPE_F32, TYPE_F64: begin
            b    = work[7:0];
            rest = work >> 8;
            done = (typ == TYPE_F32) ? (cnt == 4'd3) : (cnt == 4'd7);
         end
         default: begin
            low7 = work[6:0];
            if (sgn) begin
               rest = $signed(work) >>> 7;
               // Signed termination also needs the sign bit of the emitted
               // group to match the remaining sign fill.
               done = ((rest == 64'd0) && !low7[6]) ||
                      ((rest == {64{1'b1}}) && low7[6]);
            end else begin
               rest = work >> 7;
               done = (rest == 64'd0);
            end
            // Hard length cap; coincides with natural termination for
            // properly extended values, so no payload is actually lost.
            if ((typ == TYPE_I32) && (cnt == 4'd4)) begin
               done = 1'b1;
            end else if ((typ == TYPE_I64) && (cnt == 4'd9)) begin
               done = 1'b1;
            end else begin
               done = done;
            end
            b = {~done, low7};
         end
      endcase
      return {rest, done, b};
   endfunction

   // Extend the incoming value to the 64-bit working width by type.
   always_comb begin
      w_ext = in_value;
      case (in_type)
         TYPE_I32: w_ext = in_signed ? {{32{in_value[31]}}, in_value[31:0]}
                                     : {32'd0, in_value[31:0]};
         TYPE_F32: w_ext = {32'd0, in_value[31:0]};
         default:  w_ext = in_value;
      endcase
   end

   // Step source: fresh input while idle, the working register while emitting.
   always_comb begin
      w_src_work   = r_work;
      w_src_type   = r_type;
      w_src_signed = r_signed;
      w_src_cnt    = r_cnt;
      if (r_state == ST_IDLE) begin
         w_src_work   = w_ext;
         w_src_type   = in_type;
         w_src_signed = in_signed;
         w_src_cnt    = 4'd0;
      end else begin
         w_src_work   = r_work;
         w_src_type   = r_type;
         w_src_signed = r_signed;
         w_src_cnt    = r_cnt;
      end
   end

   assign w_step       = enc_step(w_src_work, w_src_type, w_src_signed, w_src_cnt);
   assign w_rest       = w_step[72:9];
   assign w_done       = w_step[8];
   assign w_byte       = w_step[7:0];
   assign w_byte_taken = r_out_valid && out_ready;

   // Control FSM, working register and registered byte output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_work      <= 64'd0;
         r_type      <= 2'd0;
         r_signed    <= 1'b0;
         r_cnt       <= 4'd0;
         r_out_byte  <= 8'h00;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  // First byte is computed from the input directly so it is
                  // presented on the cycle after acceptance.
                  r_state     <= ST_EMIT;
                  r_work      <= w_rest;
                  r_type      <= in_type;
                  r_signed    <= in_signed;
                  r_cnt       <= 4'd1;
                  r_out_byte  <= w_byte;
                  r_out_last  <= w_done;
                  r_out_valid <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (w_byte_taken) begin
                  if (r_out_last) begin
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_byte  <= 8'h00;
                  end else begin
                     r_work     <= w_rest;
                     r_cnt      <= r_cnt + 4'd1;
                     r_out_byte <= w_byte;
                     r_out_last <= w_done;
                  end
               end else begin
                  r_state <= ST_EMIT;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_byte  = r_out_byte;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_leb128_encoder.sv
// -----------------------------------------------------------------------------
// tb_leb128_encoder
// Scoreboard bench for leb128_encoder: expected {last, byte} pairs are queued
// when a value is sent and compared as the encoder hands each byte over.
// -----------------------------------------------------------------------------
module tb_leb128_encoder;

   localparam logic [1:0] T_I32 = 2'd0;
   localparam logic [1:0] T_I64 = 2'd1;
   localparam logic [1:0] T_F32 = 2'd2;
   localparam logic [1:0] T_F64 = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_value;
   logic [1:0]  in_type;
   logic        in_signed;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [8:0]  sb_q[$];

   leb128_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_value  (in_value),
      .in_type   (in_type),
      .in_signed (in_signed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Queue n expected bytes; byte i is bytes[8*i +: 8], last on the final one.
   task automatic expect_bytes(input logic [79:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back({(i == n - 1), bytes[8*i +: 8]});
      end
   endtask

   task automatic send(input logic [63:0] v, input logic [1:0] t, input logic s);
      int cyc = 0;
      @(negedge clk);
      out_ready = 1'b0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("send_in_ready", in_ready, 1);
      in_value  = v;
      in_type   = t;
      in_signed = s;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("first_byte_latency", out_valid, 1);
   endtask

   // Take bytes until out_last (or max_bytes), optionally stalling out_ready
   // for stall_len cycles while byte index stall_idx is on the output.
   task automatic drain(input int max_bytes, input int stall_idx, input int stall_len);
      int         taken   = 0;
      int         stalled = 0;
      int         cyc     = 0;
      bit         fin     = 1'b0;
      logic [8:0] e;
      while (!fin && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (taken == stall_idx && stalled < stall_len) begin
            out_ready = 1'b0;
            in_valid  = (stalled % 2 == 0);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("busy_in_ready", in_ready, 0);
            if (sb_q.size() > 0) begin
               check_eq("stall_byte_held", {out_last, out_byte}, sb_q[0]);
            end else begin
               check_eq("stall_sb_empty", sb_q.size(), 1);
            end
            stalled++;
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
               if (sb_q.size() == 0) begin
                  check_eq("sb_underflow", sb_q.size(), 1);
                  fin = 1'b1;
               end else begin
                  e = sb_q.pop_front();
                  check_eq("out_byte", out_byte, e[7:0]);
                  check_eq("out_last", out_last, e[8]);
                  taken++;
                  if (e[8] || taken == max_bytes) fin = 1'b1;
               end
            end
         end
      end
      if (!fin) check_eq("drain_timeout", cyc, 0);
   endtask

   initial begin
      reset     = 1'b0;
      in_value  = 64'd0;
      in_type   = 2'd0;
      in_signed = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_last", out_last, 0);
      check_eq("rst_out_byte", out_byte, 8'h00);
      reset = 1'b1;

      // i32 unsigned 624485, then in_ready returns right after the last byte.
      send(64'd624485, T_I32, 1'b0);
      expect_bytes(80'h26_8E_E5, 3);
      drain(99, -1, 0);
      @(negedge clk);
      check_eq("idle_in_ready", in_ready, 1);
      check_eq("idle_out_valid", out_valid, 0);

      send(-64'sd123456, T_I64, 1'b1);
      expect_bytes(80'h78_BB_C0, 3);
      drain(99, -1, 0);
      send(64'd3, T_I32, 1'b1);
      expect_bytes(80'h03, 1);
      drain(99, -1, 0);

      send(64'h0000_0000_FFFF_FFFF, T_I32, 1'b0);
      expect_bytes(80'h0F_FF_FF_FF_FF, 5);
      drain(99, -1, 0);
      send(64'hFFFF_FFFF_FFFF_FFFF, T_I64, 1'b1);
      expect_bytes(80'h7F, 1);
      drain(99, -1, 0);

      // Upper bits of an i32 must be ignored; i64 max uses the full 10 bytes.
      send(64'hDEAD_BEEF_0000_0080, T_I32, 1'b0);
      expect_bytes(80'h01_80, 2);
      drain(99, -1, 0);
      send(64'h1234_5678_FFFF_FFFF, T_I32, 1'b1);
      expect_bytes(80'h7F, 1);
      drain(99, -1, 0);
      send(64'hFFFF_FFFF_FFFF_FFFF, T_I64, 1'b0);
      expect_bytes(80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10);
      drain(99, -1, 0);

      send(64'hAAAA_AAAA_3F80_0000, T_F32, 1'b1);
      expect_bytes(80'h3F_80_00_00, 4);
      drain(99, -1, 0);
      send(64'h3FF0_0000_0000_0000, T_F64, 1'b0);
      expect_bytes(80'h3F_F0_00_00_00_00_00_00, 8);
      drain(99, -1, 0);

      // Backpressure on byte 2 with in_valid toggling while busy.
      send(64'd624485, T_I32, 1'b0);
      expect_bytes(80'h26_8E_E5, 3);
      drain(99, 1, 3);

      // Reset while byte 2 of 0xFFFFFFFF is on the output.
      send(64'h0000_0000_FFFF_FFFF, T_I32, 1'b0);
      expect_bytes(80'h0F_FF_FF_FF_FF, 5);
      drain(1, -1, 0);
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("pre_rst_byte2", out_byte, 8'hFF);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_in_ready", in_ready, 1);
      check_eq("midrst_out_byte", out_byte, 8'h00);
      sb_q.delete();
      repeat (2) @(negedge clk);
      check_eq("postrst_no_bytes", out_valid, 0);
      send(64'd5, T_I32, 1'b0);
      expect_bytes(80'h05, 1);
      drain(99, -1, 0);

      @(negedge clk);
      check_eq("sb_leftover", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
